// File: rtl/data_memory_mips_sized_if.sv
// Request/acknowledge bundle between the MEM stage and the sized data memory.
// The master issues requests; the slave (the memory) returns the registered acknowledge.
interface data_memory_mips_sized_if #(
    parameter int ADDR_W = 32
);
    logic              in_req;
    logic              in_we;
    logic [1:0]        in_size;
    logic              in_unsigned;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_write_data;
    logic [31:0]       out_read_data;
    logic              out_valid;
    logic              out_fault;

    modport master (
        output in_req, in_we, in_size, in_unsigned, in_addr, in_write_data,
        input  out_read_data, out_valid, out_fault
    );

    modport slave (
        input  in_req, in_we, in_size, in_unsigned, in_addr, in_write_data,
        output out_read_data, out_valid, out_fault
    );
endinterface

// File: rtl/data_memory_mips_sized.sv
// Byte-addressable, little-endian data memory with byte/half/word stores, signed or
// unsigned sub-word loads, a one-cycle registered acknowledge and fault detection.
module data_memory_mips_sized #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2048
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    data_memory_mips_sized_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      read_data_d, read_data_q;
    logic             valid_d, valid_q;
    logic             fault_d, fault_q;

    size_e            size;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             misaligned;
    logic             fault;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_val;
    logic [3:0]       byte_en;
    logic [31:0]      wr_data;
    logic             wr_en;

    // NOTE: every signal gets a default at the top of the block so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        size         = size_e'(bus.in_size);
        lane         = bus.in_addr[1:0];
        idx          = bus.in_addr[IDX_W+1:2];
        // Any set bit above the word index is out of range; there is no aliasing.
        out_of_range = |(bus.in_addr >> (IDX_W + 2));
        misaligned   = 1'b0;
        byte_en      = 4'b0000;
        wr_data      = bus.in_write_data;
        load_val     = '0;

        rd_word = mem_q[idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = bus.in_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (size)
            SZ_BYTE: begin
                byte_en  = 4'b0001 << lane;
                wr_data  = {4{bus.in_write_data[7:0]}};
                load_val = bus.in_unsigned ? {24'h0, rd_byte}
                                           : {{24{rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                misaligned = bus.in_addr[0];
                byte_en    = bus.in_addr[1] ? 4'b1100 : 4'b0011;
                wr_data    = {2{bus.in_write_data[15:0]}};
                load_val   = bus.in_unsigned ? {16'h0, rd_half}
                                             : {{16{rd_half[15]}}, rd_half};
            end
            SZ_WORD: begin
                misaligned = |lane;
                byte_en    = 4'b1111;
                load_val   = rd_word;
            end
            default: misaligned = 1'b1;
        endcase

        fault = misaligned | out_of_range;
        wr_en = bus.in_req & bus.in_we & ~fault & in_rst_n;

        valid_d     = bus.in_req;
        fault_d     = bus.in_req & fault;
        read_data_d = read_data_q;
        if (bus.in_req && !bus.in_we) begin
            read_data_d = fault ? 32'h0 : load_val;
        end
    end

    // NOTE: the array has no reset; its contents survive reset by design and a
    // reset term would also stop it mapping onto RAM. Reset low gates wr_en instead.
    always_ff @(posedge in_clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem_q[idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs, independent of statement order.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            read_data_q <= 32'h0;
        end else begin
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            read_data_q <= read_data_d;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.out_fault     = fault_q;
    assign bus.out_read_data = read_data_q;
endmodule

// File: doc/data_memory_mips_sized.md
# data_memory_mips_sized

Byte-addressable, size-aware data memory for the MIPS-based soft processor's MEM stage. It replaces the word-only, combinational-read data memory and adds:
- byte, halfword and word stores through byte-lane writes;
- signed and unsigned sub-word loads;
- a registered read with a one-cycle valid handshake;
- detection of misaligned and out-of-range accesses.

Word storage depth and address width are parameters.

## Interface
- ADDR_W, 32, byte-address width.
- DEPTH, 2048, number of 32-bit words stored; must be a power of two, at least 4.
- in_clk  input  1  clock; everything is rising-edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_req  input  1  access request, sampled on the rising edge of in_clk.
- in_we  input  1  1 = store, 0 = load; meaningful only while in_req = 1.
- in_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- in_unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend; ignored for stores and word loads.
- in_addr  input  ADDR_W  byte address.
- in_write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- out_read_data  output  32  load result, registered.
- out_valid  output  1  one-cycle acknowledge of the previously accepted request.
- out_fault  output  1  qualifies out_valid: the acknowledged request was rejected.

## Operation
- Storage: DEPTH x 32-bit array, little-endian. Byte lane k (k = in_addr[1:0]) is bits [8k+7:8k]. Word index is in_addr[ADDR_W-1:2].
- Memory contents are not affected by reset and power up undefined.
- Fault conditions, evaluated in the sampling cycle:
  - size = 11;
  - halfword with in_addr[0] = 1;
  - word with in_addr[1:0] != 00;
  - word index >= DEPTH; all address bits are checked, with no aliasing or wrap.
- A faulting request:
  - never writes the array;
  - is acknowledged with out_fault = 1;
  - a faulting load sets out_read_data = 0;
  - a faulting store leaves out_read_data unchanged.
- Store, non-faulting:
  - SB writes only lane addr[1:0] with wdata[7:0];
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - SW writes all 4 lanes;
  - unselected lanes keep their contents;
  - out_read_data is unchanged.
- Load, non-faulting:
  - the selected byte or half is moved to bit 0;
  - it is then extended from bit 7 or 15 according to in_unsigned;
  - a word load returns the stored word as-is.
- No request in flight (in_req = 0): out_valid = 0, out_fault = 0, and out_read_data holds its value.
- No internal state machine beyond the acknowledge register.
- The block accepts one request per cycle and never stalls; no back-pressure input exists.

## Timing
- Reset (in_rst_n = 0), immediate and asynchronous:
  - out_valid = 0, out_fault = 0, out_read_data = 0;
  - no array write occurs while reset is low, even if in_req and in_we are high at a clock edge.
- Request sampled at edge k:
  - the store takes effect at edge k;
  - out_valid, out_fault and out_read_data are updated at edge k and held until edge k+1;
  - load latency is 1 cycle.
- Back-to-back: a store at edge k followed by a load of the same word at edge k+1 returns the new data.
- Reset asserted between edge k and edge k+1 clears the acknowledge. A store already committed at edge k stays in the array.
- Reset deassertion is synchronised externally; the first request can be accepted on the first edge after release.

## Test plan
- Reset behaviour:
  - stimulus: hold in_rst_n = 0 while in_req = 1, in_we = 1, addr 0x0, SW 0xDEADBEEF for 2 edges; release; then LW 0x0;
  - during reset: outputs stay at 0;
  - after release: LW 0x0 returns the pre-reset contents (write it first with a known value), proving no write occurred.
- Store then word load:
  - stimulus: SW 0x11223344 @0x10, then at the next edge SB 0xAA @0x11, then LW 0x10;
  - required: out_read_data = 0x1122AA44 one cycle after the LW edge, with out_valid = 1 and out_fault = 0.
- Sign and zero extension:
  - stimulus: after SW 0x80F07F01 @0x20, issue LB 0x23, LBU 0x23, LH 0x22, LHU 0x22, LB 0x20;
  - required results: 0xFFFFFF80, 0x00000080, 0xFFFF80F0, 0x000080F0, 0x00000001.
- Misalignment:
  - stimulus: SH @0x21 and SW @0x22, then LW 0x20;
  - required: both stores give out_valid = 1 and out_fault = 1, and the LW still returns 0x80F07F01;
  - stimulus: LH @0x23;
  - required: out_fault = 1, out_read_data = 0.
- Range and reserved size (DEPTH = 2048):
  - stimulus: LW @0x1FFC;
  - required: OK, no fault;
  - stimulus: LW @0x2000, SW @0x80000000, and in_size = 11;
  - required: each gives out_fault = 1 with no array change; word 0 remains intact.
- Pipelined stream:
  - stimulus: 16 consecutive requests alternating SW and LW of the same word with incrementing data;
  - required: each LW returns the data of the immediately preceding SW;
  - required: out_valid is high for exactly 16 consecutive cycles.
